// File: rtl/stopwatch_draw.sv
// stopwatch_draw: MM:SS play-time stopwatch, counted in video frames and
// drawn as a five-glyph text box for the object priority mux.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | stopped at zero (after reset or clearP), waiting for startP
// S_RUNNING | counting one second every FRAMES_PER_SEC frames
// S_PAUSED  | holding time and sub-second fraction, waiting for startP
module stopwatch_draw #(
  parameter logic [10:0] TOP_LEFT_X     = 11'd16,
  parameter logic [10:0] TOP_LEFT_Y     = 11'd16,
  parameter int          FRAMES_PER_SEC = 60,
  parameter logic [7:0]  DIGIT_COLOR    = 8'hFF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        startP,
  input  logic        pauseP,
  input  logic        clearP,
  output logic        stopwatchDrawingRequest,
  output logic [7:0]  stopwatchRGB,
  output logic        running,
  output logic        maxed
);

  localparam logic [7:0] FRAME_LAST  = 8'(FRAMES_PER_SEC - 1);
  localparam logic [3:0] GLYPH_COLON = 4'd10;

  // 8x16 glyphs, 16 rows each: digits 0..9 then the colon. Bit 7 is the leftmost column.
  localparam logic [7:0] FONT [0:175] = '{
    8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE, 8'hF6, 8'hE6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h7C, 8'hC6, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC6, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h7C, 8'hC6, 8'h06, 8'h06, 8'h3C, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'hFE, 8'hC0, 8'hC0, 8'hC0, 8'hFC, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h38, 8'h60, 8'hC0, 8'hC0, 8'hFC, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'hFE, 8'hC6, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7E, 8'h06, 8'h06, 8'h06, 8'h0C, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_frame_cnt;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;

  logic        w_count;
  logic        w_maxed;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_box;
  logic [2:0]  w_cell;
  logic [3:0]  w_row;
  logic [2:0]  w_col;
  logic [3:0]  w_glyph;
  logic [7:0]  w_rom_addr;
  logic [7:0]  w_font_byte;
  logic        w_pixel_on;

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: clearP beats pauseP beats startP; a higher-priority pulse
  // that is present masks the lower ones even when it is itself ignored.
  always_comb begin
    w_state_nxt = r_state;
    if (clearP) begin
      w_state_nxt = S_IDLE;
    end else if (pauseP) begin
      if (r_state == S_RUNNING) w_state_nxt = S_PAUSED;
    end else if (startP) begin
      if (r_state != S_RUNNING) w_state_nxt = S_RUNNING;
    end
  end

  assign running = (r_state == S_RUNNING);
  assign w_maxed = (r_min_tens == 4'd9) && (r_min_ones == 4'd9) &&
                   (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);
  assign maxed   = w_maxed;
  // Counting looks at the pre-transition state, so a pauseP on a frame edge still counts that frame.
  assign w_count = startOfFrame && (r_state == S_RUNNING) && !clearP;

  // Frame prescaler and BCD time with carries; saturates at 99:59.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt <= 8'd0;
      r_sec_ones  <= 4'd0;
      r_sec_tens  <= 4'd0;
      r_min_ones  <= 4'd0;
      r_min_tens  <= 4'd0;
    end else if (clearP) begin
      r_frame_cnt <= 8'd0;
      r_sec_ones  <= 4'd0;
      r_sec_tens  <= 4'd0;
      r_min_ones  <= 4'd0;
      r_min_tens  <= 4'd0;
    end else if (w_count) begin
      if (w_maxed) begin
        r_frame_cnt <= 8'd0;
      end else if (r_frame_cnt == FRAME_LAST) begin
        r_frame_cnt <= 8'd0;
        if (r_sec_ones != 4'd9) begin
          r_sec_ones <= r_sec_ones + 4'd1;
        end else begin
          r_sec_ones <= 4'd0;
          if (r_sec_tens != 4'd5) begin
            r_sec_tens <= r_sec_tens + 4'd1;
          end else begin
            r_sec_tens <= 4'd0;
            if (r_min_ones != 4'd9) begin
              r_min_ones <= r_min_ones + 4'd1;
            end else begin
              r_min_ones <= 4'd0;
              r_min_tens <= r_min_tens + 4'd1;
            end
          end
        end
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // Box-relative coordinates; the >= guards stop wrap-around left of / above the box.
  assign w_dx     = pixelX - TOP_LEFT_X;
  assign w_dy     = pixelY - TOP_LEFT_Y;
  assign w_in_box = (pixelX >= TOP_LEFT_X) && (pixelY >= TOP_LEFT_Y) &&
                    (w_dx < 11'd80) && (w_dy < 11'd32);
  assign w_cell   = w_dx[6:4];
  assign w_col    = w_dx[3:1];
  assign w_row    = w_dy[4:1];

  // Pick the glyph shown in the current cell.
  always_comb begin
    w_glyph = r_sec_ones;
    case (w_cell)
      3'd0:    w_glyph = r_min_tens;
      3'd1:    w_glyph = r_min_ones;
      3'd2:    w_glyph = GLYPH_COLON;
      3'd3:    w_glyph = r_sec_tens;
      default: w_glyph = r_sec_ones;
    endcase
  end

  assign w_rom_addr  = {w_glyph, w_row};
  assign w_font_byte = FONT[w_rom_addr];
  assign w_pixel_on  = w_in_box && w_font_byte[3'd7 - w_col];

  // Single output register stage towards the priority mux.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stopwatchDrawingRequest <= 1'b0;
      stopwatchRGB            <= 8'h00;
    end else begin
      stopwatchDrawingRequest <= w_pixel_on;
      stopwatchRGB            <= w_pixel_on ? DIGIT_COLOR : 8'h00;
    end
  end

endmodule

// File: tb/tb_stopwatch_draw.sv
// Bench for stopwatch_draw: directed stimulus pushes expectations into a
// scoreboard queue; a separate monitor pops and compares at the due cycle.
module tb_stopwatch_draw;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        sof, startP, pauseP, clearP;
  logic        sof1, start1, pause1, clear1;
  logic        req, req1;
  logic [7:0]  rgb, rgb1;
  logic        run, run1, mx, mx1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int          q_due[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];
  string       q_name[$];
  event        chk_ev;

  localparam int SEL_REQ = 0, SEL_RGB = 1, SEL_RUN = 2, SEL_MAX = 3,
                 SEL_TIME = 4, SEL_FRAME = 5, SEL_TIME1 = 6, SEL_MAX1 = 7, SEL_RUN1 = 8;

  stopwatch_draw dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(sof), .startP(startP), .pauseP(pauseP), .clearP(clearP),
    .stopwatchDrawingRequest(req), .stopwatchRGB(rgb), .running(run), .maxed(mx)
  );

  // One frame per second, so saturation is reachable in a few thousand cycles.
  stopwatch_draw #(.FRAMES_PER_SEC(1)) dut1 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(sof1), .startP(start1), .pauseP(pause1), .clearP(clear1),
    .stopwatchDrawingRequest(req1), .stopwatchRGB(rgb1), .running(run1), .maxed(mx1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_REQ:   return {31'd0, req};
      SEL_RGB:   return {24'd0, rgb};
      SEL_RUN:   return {31'd0, run};
      SEL_MAX:   return {31'd0, mx};
      SEL_TIME:  return {16'd0, dut.r_min_tens, dut.r_min_ones, dut.r_sec_tens, dut.r_sec_ones};
      SEL_FRAME: return {24'd0, dut.r_frame_cnt};
      SEL_TIME1: return {16'd0, dut1.r_min_tens, dut1.r_min_ones, dut1.r_sec_tens, dut1.r_sec_ones};
      SEL_MAX1:  return {31'd0, mx1};
      SEL_RUN1:  return {31'd0, run1};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every expectation due by now, on each negedge or on demand.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (q_due.size() > 0 && q_due[0] <= cyc) begin
        logic [31:0] a;
        a = actual(q_sel[0]);
        n_checks++;
        if (a !== q_exp[0]) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", q_name[0], a, q_exp[0], cyc);
        end
        void'(q_due.pop_front());
        void'(q_sel.pop_front());
        void'(q_exp.pop_front());
        void'(q_name.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a value visible at the negedge of the current cycle.
  task automatic exp_now(input int sel, input logic [31:0] e, input string name);
    q_due.push_back(cyc);
    q_sel.push_back(sel);
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1;
      tick();
    end
    sof = 1'b0;
  endtask

  task automatic frames1(input int n);
    for (int i = 0; i < n; i++) begin
      sof1 = 1'b1;
      tick();
    end
    sof1 = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p, input logic c, input logic f);
    startP = s; pauseP = p; clearP = c; sof = f;
    tick();
    startP = 1'b0; pauseP = 1'b0; clearP = 1'b0; sof = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic e_req, input string name);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    exp_now(SEL_REQ, {31'd0, e_req}, {name, "_req"});
    exp_now(SEL_RGB, e_req ? 32'hFF : 32'h00, {name, "_rgb"});
  endtask

  initial begin
    resetN = 1'b0;
    pixelX = 11'd0; pixelY = 11'd0;
    sof = 0; startP = 0; pauseP = 0; clearP = 0;
    sof1 = 0; start1 = 0; pause1 = 0; clear1 = 0;

    repeat (2) tick();
    exp_now(SEL_REQ, 0, "rst_req");
    exp_now(SEL_RGB, 0, "rst_rgb");
    exp_now(SEL_RUN, 0, "rst_running");
    exp_now(SEL_MAX, 0, "rst_maxed");
    exp_now(SEL_TIME, 0, "rst_time");
    exp_now(SEL_FRAME, 0, "rst_frame");
    tick();
    resetN = 1'b1;
    tick();

    // Start and count one second
    pulse(1, 0, 0, 0);
    exp_now(SEL_RUN, 1, "start_running");
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_start_running: got %b", run);
    end
    frames(59);
    exp_now(SEL_TIME, 16'h0000, "f59_time");
    exp_now(SEL_FRAME, 59, "f59_frame");
    frames(1);
    exp_now(SEL_TIME, 16'h0001, "f60_time");
    exp_now(SEL_FRAME, 0, "f60_frame");
    exp_now(SEL_RUN, 1, "f60_running");
    n_checks++;
    if ({dut.r_min_tens, dut.r_min_ones, dut.r_sec_tens, dut.r_sec_ones} !== 16'h0001) begin
      n_fail++;
      $display("FAIL direct_f60_time");
    end

    // Rendering at 00:01
    pix(16, 16, 1'b0, "px_16_16");
    pix(18, 20, 1'b1, "px_mt0_row2");
    pix(86, 20, 1'b1, "px_so1_row2");
    pix(82, 38, 1'b1, "px_so1_row11");
    pix(15, 20, 1'b0, "px_x15");
    pix(96, 20, 1'b0, "px_x96");
    pix(54, 24, 1'b1, "px_colon_dot");
    pix(54, 20, 1'b0, "px_colon_blank");

    // Pause keeps the fraction
    pulse(0, 0, 1, 0);
    exp_now(SEL_RUN, 0, "clr_running");
    exp_now(SEL_TIME, 0, "clr_time");
    pulse(1, 0, 0, 0);
    frames(30);
    exp_now(SEL_FRAME, 30, "pre_pause_frame");
    pulse(0, 1, 0, 0);
    exp_now(SEL_RUN, 0, "paused_running");
    frames(100);
    exp_now(SEL_TIME, 16'h0000, "paused_time");
    exp_now(SEL_FRAME, 30, "paused_frame");
    pulse(1, 0, 0, 0);
    exp_now(SEL_RUN, 1, "resume_running");
    frames(30);
    exp_now(SEL_TIME, 16'h0001, "resume_time");
    exp_now(SEL_FRAME, 0, "resume_frame");

    // Coincident pulses on a frame edge
    frames(240);
    exp_now(SEL_TIME, 16'h0005, "t0005");
    pulse(1, 1, 0, 1);
    exp_now(SEL_RUN, 0, "pause_over_start");
    exp_now(SEL_FRAME, 1, "pause_edge_counted");
    pulse(1, 0, 0, 0);
    exp_now(SEL_RUN, 1, "restart_running");
    pulse(1, 1, 1, 1);
    exp_now(SEL_RUN, 0, "allpulse_running");
    exp_now(SEL_TIME, 0, "allpulse_time");
    exp_now(SEL_FRAME, 0, "allpulse_frame");
    n_checks++;
    if (run !== 1'b0 || dut.r_frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL direct_allpulse: run=%b frame=%0d", run, dut.r_frame_cnt);
    end

    // Ignored pulses
    pulse(0, 1, 0, 0);
    exp_now(SEL_RUN, 0, "pause_in_idle");
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    exp_now(SEL_RUN, 1, "start_in_running");

    // 09:59 -> 10:00
    frames(35999);
    exp_now(SEL_TIME, 16'h0959, "t0959");
    exp_now(SEL_FRAME, 59, "t0959_frame");
    frames(1);
    exp_now(SEL_TIME, 16'h1000, "t1000");
    exp_now(SEL_FRAME, 0, "t1000_frame");

    // Saturation on the one-frame-per-second instance
    start1 = 1'b1; tick(); start1 = 1'b0;
    frames1(5998);
    exp_now(SEL_TIME1, 16'h9958, "t9958");
    exp_now(SEL_MAX1, 0, "t9958_maxed");
    frames1(1);
    exp_now(SEL_TIME1, 16'h9959, "t9959");
    exp_now(SEL_MAX1, 1, "t9959_maxed");
    frames1(60);
    exp_now(SEL_TIME1, 16'h9959, "sat_time");
    exp_now(SEL_MAX1, 1, "sat_maxed");
    exp_now(SEL_RUN1, 1, "sat_running");
    exp_now(SEL_MAX, 0, "main_not_maxed");
    n_checks++;
    if (mx1 !== 1'b1 || run1 !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_sat: maxed=%b running=%b", mx1, run1);
    end
    clear1 = 1'b1; tick(); clear1 = 1'b0;
    exp_now(SEL_MAX1, 0, "sat_clr_maxed");
    exp_now(SEL_TIME1, 0, "sat_clr_time");

    // Asynchronous reset mid-line
    pix(54, 24, 1'b1, "pre_rst_colon");
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    exp_now(SEL_REQ, 0, "async_rst_req");
    exp_now(SEL_RGB, 0, "async_rst_rgb");
    exp_now(SEL_RUN, 0, "async_rst_running");
    exp_now(SEL_TIME, 0, "async_rst_time");
    -> chk_ev;
    tick();
    resetN = 1'b1;
    repeat (3) tick();

    while (q_due.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never compared, expected 0x%0h", q_name[0], q_exp[0]);
      void'(q_due.pop_front());
      void'(q_sel.pop_front());
      void'(q_exp.pop_front());
      void'(q_name.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
